// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock-setting controller.
// Holds the FSM state type, the BCD time record, the 12:00 reset value,
// the hour/minute limits and the BCD increment helpers.
package clock_set_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetHr  = 2'd1,
    StSetMin = 2'd2,
    StCommit = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] hr_hi;
    logic [3:0] hr_lo;
    logic [3:0] min_hi;
    logic [3:0] min_lo;
  } bcd_time_t;

  localparam bcd_time_t ResetTime = '{hr_hi: 4'd1, hr_lo: 4'd2, min_hi: 4'd0, min_lo: 4'd0};

  localparam logic [3:0] HrMaxHi  = 4'd1;
  localparam logic [3:0] HrMaxLo  = 4'd2;
  localparam logic [3:0] HrMinHi  = 4'd0;
  localparam logic [3:0] HrMinLo  = 4'd1;
  localparam logic [3:0] MinMaxHi = 4'd5;
  localparam logic [3:0] MinMaxLo = 4'd9;
  localparam logic [3:0] DigitMax = 4'd9;

  // Hours run 1..12; 12 wraps to 01, x9 carries into the tens digit.
  function automatic bcd_time_t inc_hours(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.hr_hi == HrMaxHi && t.hr_lo == HrMaxLo) begin
      r.hr_hi = HrMinHi;
      r.hr_lo = HrMinLo;
    end else if (t.hr_lo == DigitMax) begin
      r.hr_hi = t.hr_hi + 4'd1;
      r.hr_lo = 4'd0;
    end else begin
      r.hr_lo = t.hr_lo + 4'd1;
    end
    return r;
  endfunction

  // Minutes run 00..59; hours are never touched.
  function automatic bcd_time_t inc_minutes(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.min_lo == MinMaxLo) begin
      r.min_lo = 4'd0;
      r.min_hi = (t.min_hi == MinMaxHi) ? 4'd0 : t.min_hi + 4'd1;
    end else begin
      r.min_lo = t.min_lo + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer followed by a registered rising-edge
// detector. A clean rise on btn_i gives a single-cycle pulse_o three cycles later.
// A button already held when reset is released produces no pulse until it has
// been seen released.
// Ports: clk_i, rst_ni (async active-low), btn_i (raw, async), pulse_o (1-cycle press).
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic       pulse_q, pulse_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // fill_q tracks how many real samples the chain holds since reset.
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    // Arm only once a genuine released level has passed through the chain.
    armed_d = armed_q | ((fill_q == 2'd2) & ~sync2_q);
    pulse_d = armed_q & sync2_q & ~prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller. Two buttons (mode, inc) walk through
// RUN -> SET_HR -> SET_MIN -> COMMIT, editing a BCD hh:mm buffer and loading it
// into the clock datapath with an active-low strobe held for LOAD_CYC cycles.
// Edits abort back to RUN after TIMEOUT_CYC cycles without a press.
// Ports: clk_i, rst_ni (async active-low), mode_btn_i, inc_btn_i (raw buttons),
//        hr_hi_o/hr_lo_o/min_hi_o/min_lo_o (BCD value), ld_n_o (load strobe),
//        edit_hr_o/edit_min_o (field being edited). All outputs registered.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 20,
  parameter int unsigned LOAD_CYC    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       mode_btn_i,
  input  logic       inc_btn_i,
  output logic [3:0] hr_hi_o,
  output logic [3:0] hr_lo_o,
  output logic [3:0] min_hi_o,
  output logic [3:0] min_lo_o,
  output logic       ld_n_o,
  output logic       edit_hr_o,
  output logic       edit_min_o
);

  localparam int unsigned IdleW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int unsigned LdW   = (LOAD_CYC > 1) ? $clog2(LOAD_CYC + 1) : 1;
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYC - 1);
  localparam logic [LdW-1:0]   LdLast   = LdW'(LOAD_CYC - 1);

  logic mode_p, inc_p;

  btn_sync_edge u_mode_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (mode_btn_i),
    .pulse_o (mode_p)
  );

  btn_sync_edge u_inc_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (inc_btn_i),
    .pulse_o (inc_p)
  );

  state_e           state_q, state_d;
  bcd_time_t        com_q, com_d;
  bcd_time_t        edit_q, edit_d;
  bcd_time_t        disp_q, disp_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [LdW-1:0]   ld_cnt_q, ld_cnt_d;
  logic             ld_n_q, ld_n_d;
  logic             edit_hr_q, edit_hr_d;
  logic             edit_min_q, edit_min_d;

  always_comb begin
    state_d  = state_q;
    com_d    = com_q;
    edit_d   = edit_q;
    idle_d   = idle_q;
    ld_cnt_d = ld_cnt_q;
    ld_n_d   = 1'b1;

    unique case (state_q)
      StRun: begin
        if (mode_p) begin
          state_d = StSetHr;
          edit_d  = com_q;
          idle_d  = '0;
        end
      end
      StSetHr: begin
        // mode is checked first so a coincident inc is dropped.
        if (mode_p) begin
          state_d = StSetMin;
          idle_d  = '0;
        end else if (inc_p) begin
          edit_d = inc_hours(edit_q);
          idle_d = '0;
        end else if (idle_q == IdleLast) begin
          state_d = StRun;
          edit_d  = com_q;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StSetMin: begin
        if (mode_p) begin
          state_d  = StCommit;
          com_d    = edit_q;
          ld_cnt_d = '0;
          ld_n_d   = 1'b0;
        end else if (inc_p) begin
          edit_d = inc_minutes(edit_q);
          idle_d = '0;
        end else if (idle_q == IdleLast) begin
          state_d = StRun;
          edit_d  = com_q;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StCommit: begin
        // Strobe went low on entry; keep it low until LOAD_CYC cycles have elapsed.
        if (ld_cnt_q == LdLast) begin
          state_d = StRun;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          ld_n_d   = 1'b0;
        end
      end
      default: state_d = StRun;
    endcase

    edit_hr_d  = (state_d == StSetHr);
    edit_min_d = (state_d == StSetMin);
    disp_d     = (state_d == StSetHr || state_d == StSetMin) ? edit_d : com_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      com_q      <= ResetTime;
      edit_q     <= ResetTime;
      disp_q     <= ResetTime;
      idle_q     <= '0;
      ld_cnt_q   <= '0;
      ld_n_q     <= 1'b1;
      edit_hr_q  <= 1'b0;
      edit_min_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      com_q      <= com_d;
      edit_q     <= edit_d;
      disp_q     <= disp_d;
      idle_q     <= idle_d;
      ld_cnt_q   <= ld_cnt_d;
      ld_n_q     <= ld_n_d;
      edit_hr_q  <= edit_hr_d;
      edit_min_q <= edit_min_d;
    end
  end

  assign hr_hi_o    = disp_q.hr_hi;
  assign hr_lo_o    = disp_q.hr_lo;
  assign min_hi_o   = disp_q.min_hi;
  assign min_lo_o   = disp_q.min_lo;
  assign ld_n_o     = ld_n_q;
  assign edit_hr_o  = edit_hr_q;
  assign edit_min_o = edit_min_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios followed by a
// random button sequence, all checked against an integer hh:mm model.
module tb_clock_set_ctrl;

  localparam int Timeout = 20;
  localparam int LoadCyc = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic [3:0] hr_hi, hr_lo, min_hi, min_lo;
  logic       ld_n, edit_hr, edit_min;

  clock_set_ctrl #(
    .TIMEOUT_CYC (Timeout),
    .LOAD_CYC    (LoadCyc)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_btn_i (mode_btn),
    .inc_btn_i  (inc_btn),
    .hr_hi_o    (hr_hi),
    .hr_lo_o    (hr_lo),
    .min_hi_o   (min_hi),
    .min_lo_o   (min_lo),
    .ld_n_o     (ld_n),
    .edit_hr_o  (edit_hr),
    .edit_min_o (edit_min)
  );

  always #5 clk = ~clk;

  // Count every clock edge at which the load strobe is asserted.
  int ld_low_cnt = 0;
  always @(posedge clk) if (ld_n === 1'b0) ld_low_cnt++;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: st 0=run, 1=editing hours, 2=editing minutes.
  int st, com_h, com_m, ed_h, ed_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    st = 0; com_h = 12; com_m = 0; ed_h = 12; ed_m = 0;
  endtask

  task automatic model_mode();
    case (st)
      0: begin ed_h = com_h; ed_m = com_m; st = 1; end
      1: st = 2;
      default: begin com_h = ed_h; com_m = ed_m; st = 0; end
    endcase
  endtask

  task automatic model_inc();
    if (st == 1) ed_h = (ed_h == 12) ? 1 : ed_h + 1;
    else if (st == 2) ed_m = (ed_m + 1) % 60;
  endtask

  task automatic check_model(input string tag);
    int h, m;
    h = (st != 0) ? ed_h : com_h;
    m = (st != 0) ? ed_m : com_m;
    chk({tag, ".hr_hi"}, 32'(hr_hi), 32'(h / 10));
    chk({tag, ".hr_lo"}, 32'(hr_lo), 32'(h % 10));
    chk({tag, ".min_hi"}, 32'(min_hi), 32'(m / 10));
    chk({tag, ".min_lo"}, 32'(min_lo), 32'(m % 10));
    chk({tag, ".edit_hr"}, 32'(edit_hr), 32'(st == 1));
    chk({tag, ".edit_min"}, 32'(edit_min), 32'(st == 2));
    chk({tag, ".ld_n"}, 32'(ld_n), 32'd1);
  endtask

  task automatic do_reset();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
  endtask

  // Raise the chosen buttons together, hold 3 cycles, release, settle 5 cycles.
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    mode_btn = m;
    inc_btn  = i;
    repeat (3) @(negedge clk);
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (5) @(negedge clk);
    if (m) model_mode();
    else if (i) model_inc();
  endtask

  initial begin
    int ld0;
    int ok;
    int found;

    // Reset state and 100 quiet cycles.
    do_reset();
    check_model("reset");
    ld0 = ld_low_cnt;
    ok  = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if ({hr_hi, hr_lo, min_hi, min_lo} !== 16'h1200 || ld_n !== 1'b1) ok = 0;
    end
    chk("idle100.stable", 32'(ok), 32'd1);
    chk("idle100.no_strobe", 32'(ld_low_cnt - ld0), 32'd0);

    // Set 01:05.
    press(1, 0);
    check_model("seq.set_hr");
    press(0, 1);
    check_model("seq.hr_inc");
    press(1, 0);
    for (int k = 0; k < 5; k++) press(0, 1);
    check_model("seq.min5");
    ld0 = ld_low_cnt;
    press(1, 0);
    chk("seq.strobe_len", 32'(ld_low_cnt - ld0), 32'(LoadCyc));
    check_model("seq.commit");
    chk("seq.value", 32'({hr_hi, hr_lo, min_hi, min_lo}), 32'h0105);

    // Hours 09 -> 10, 12 -> 01; minutes 59 -> 00.
    do_reset();
    press(1, 0);
    for (int k = 0; k < 9; k++) press(0, 1);
    chk("hr09", 32'({hr_hi, hr_lo}), 32'h09);
    press(0, 1);
    chk("hr10", 32'({hr_hi, hr_lo}), 32'h10);
    press(0, 1);
    press(0, 1);
    chk("hr12", 32'({hr_hi, hr_lo}), 32'h12);
    press(0, 1);
    chk("hr_wrap", 32'({hr_hi, hr_lo}), 32'h01);
    press(1, 0);
    for (int k = 0; k < 59; k++) press(0, 1);
    chk("min59", 32'({min_hi, min_lo}), 32'h59);
    press(0, 1);
    chk("min_wrap", 32'({hr_hi, hr_lo, min_hi, min_lo}), 32'h0100);
    check_model("wrap");

    // Timeout in SET_MIN discards the edit, no strobe.
    do_reset();
    ld0 = ld_low_cnt;
    press(1, 0);
    press(1, 0);
    press(0, 1);
    press(0, 1);
    check_model("to.editing");
    repeat (Timeout + 8) @(negedge clk);
    st = 0;
    check_model("to.abort");
    chk("to.no_strobe", 32'(ld_low_cnt - ld0), 32'd0);

    // Simultaneous mode+inc in SET_HR: mode wins.
    press(1, 0);
    press(0, 1);
    press(1, 1);
    check_model("simul");
    chk("simul.hr", 32'({hr_hi, hr_lo}), 32'h01);

    // Reset during the commit strobe.
    @(negedge clk);
    mode_btn = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(posedge clk);
      #1;
      if (ld_n === 1'b0) found = 1;
    end
    chk("rst_commit.strobe_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    mode_btn = 1'b0;
    #1;
    chk("rst_commit.ld_n_async", 32'(ld_n), 32'd1);
    ld0 = ld_low_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    model_reset();
    check_model("rst_commit.after");
    chk("rst_commit.no_more_strobe", 32'(ld_low_cnt - ld0), 32'd0);

    // Button held through reset release must not register.
    @(negedge clk);
    mode_btn = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_model("held.no_press");
    mode_btn = 1'b0;
    repeat (5) @(negedge clk);
    press(1, 0);
    check_model("held.then_press");

    // Random sequence against the model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int op;
      int was_commit;
      op = int'($urandom_range(0, 9));
      was_commit = (st == 2);
      ld0 = ld_low_cnt;
      if (op <= 2) begin
        press(1, 0);
        chk("rnd.strobe", 32'(ld_low_cnt - ld0), was_commit ? 32'(LoadCyc) : 32'd0);
      end else if (op <= 7) begin
        press(0, 1);
      end else if (op == 8) begin
        press(1, 1);
        chk("rnd.strobe2", 32'(ld_low_cnt - ld0), was_commit ? 32'(LoadCyc) : 32'd0);
      end else begin
        repeat (Timeout + 8) @(negedge clk);
        st = 0;
        chk("rnd.to_strobe", 32'(ld_low_cnt - ld0), 32'd0);
      end
      check_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
